// File: rtl/dma_2d_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dma_2d_pkg
// Description : Shared types and constants for the 2D DMA descriptor scheduler
// Revision    : 1.0 - initial release
// ============================================================================
package dma_2d_pkg;

    localparam int c_WDOG_W     = 32;
    localparam int c_DONE_CNT_W = 16;
    localparam int c_ERR_W      = 2;
    localparam int c_ERR_WDOG   = 0;
    localparam int c_ERR_REJ    = 1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_START  = 3'd2,
        ST_WAIT   = 3'd3,
        ST_RETIRE = 3'd4,
        ST_ERROR  = 3'd5
    } state_e;

    // The watchdog must never wrap back to zero and hide a hung engine.
    function automatic logic [c_WDOG_W-1:0] sat_inc(input logic [c_WDOG_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage : dma_2d_pkg
`default_nettype wire

// File: rtl/dma_2d_desc_fifo.sv
`default_nettype none
// ============================================================================
// Module      : dma_2d_desc_fifo
// Description : Synchronous descriptor FIFO with wrap-bit pointers and level
// Revision    : 1.0 - initial release
// ============================================================================
module dma_2d_desc_fifo #(
    parameter int WIDTH = 160,
    parameter int DEPTH = 4
) (
    input  logic                     ACLK,
    input  logic                     ARESETN,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_rdata,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (wr_ptr_q == rd_ptr_q);
    assign o_full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign o_level   = wr_ptr_q - rd_ptr_q;
    assign o_rdata   = mem_q[rd_ptr_q[AW-1:0]];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (w_do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (w_do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: the pointers alone define what is valid.
    always_ff @(posedge ACLK) begin
        if (w_do_push) mem_q[wr_ptr_q[AW-1:0]] <= i_wdata;
    end

endmodule : dma_2d_desc_fifo
`default_nettype wire

// File: rtl/dma_2d_desc_sched.sv
`default_nettype none
// ============================================================================
// Module      : dma_2d_desc_sched
// Description : Queues 2D DMA descriptors and launches them one at a time
// Revision    : 1.0 - initial release
// ============================================================================
module dma_2d_desc_sched
    import dma_2d_pkg::*;
#(
    parameter int          QUEUE_DEPTH = 4,
    parameter int          ADDR_WIDTH  = 32,
    parameter int          DIM_WIDTH   = 32,
    parameter int unsigned WDOG_CYCLES = 1048576
) (
    input  logic                           ACLK,
    input  logic                           ARESETN,
    input  logic                           i_desc_valid,
    output logic                           o_desc_ready,
    input  logic [ADDR_WIDTH-1:0]          i_desc_src,
    input  logic [ADDR_WIDTH-1:0]          i_desc_dst,
    input  logic [DIM_WIDTH-1:0]           i_desc_width,
    input  logic [DIM_WIDTH-1:0]           i_desc_height,
    input  logic [DIM_WIDTH-1:0]           i_desc_stride,
    input  logic                           i_enable,
    input  logic                           i_clear_err,
    output logic                           o_dma_start,
    output logic [ADDR_WIDTH-1:0]          o_src_addr,
    output logic [ADDR_WIDTH-1:0]          o_dst_addr,
    output logic [DIM_WIDTH-1:0]           o_img_width,
    output logic [DIM_WIDTH-1:0]           o_img_height,
    output logic [DIM_WIDTH-1:0]           o_img_stride,
    input  logic                           i_dma_done,
    output logic                           o_busy,
    output logic [$clog2(QUEUE_DEPTH):0]   o_q_level,
    output logic [15:0]                    o_done_cnt,
    output logic                           o_irq,
    output logic [1:0]                     o_err
);

    localparam int c_DESC_W  = 2*ADDR_WIDTH + 3*DIM_WIDTH;
    localparam int c_OFS_DST = 3*DIM_WIDTH;
    localparam int c_OFS_SRC = 3*DIM_WIDTH + ADDR_WIDTH;
    localparam logic [c_WDOG_W-1:0] c_WDOG_LIMIT = c_WDOG_W'(WDOG_CYCLES);
    localparam logic                c_WDOG_EN    = (WDOG_CYCLES != 0);

    state_e                  state_q, state_d;
    logic                    done_q, done_d;
    logic [c_WDOG_W-1:0]     wdog_q, wdog_d;
    logic [ADDR_WIDTH-1:0]   src_q, src_d, dst_q, dst_d;
    logic [DIM_WIDTH-1:0]    width_q, width_d, height_q, height_d, stride_q, stride_d;
    logic                    start_q, start_d;
    logic                    irq_q, irq_d;
    logic                    busy_q, busy_d;
    logic [c_DONE_CNT_W-1:0] done_cnt_q, done_cnt_d;
    logic [c_ERR_W-1:0]      err_q, err_d;

    logic                    w_full, w_empty, w_pop, w_take, w_dims_ok, w_push, w_reject;
    logic [c_DESC_W-1:0]     w_wdata, w_head;

    assign w_take    = i_desc_valid && !w_full;
    assign w_dims_ok = (i_desc_width != '0) && (i_desc_height != '0);
    assign w_push    = w_take && w_dims_ok;
    assign w_reject  = w_take && !w_dims_ok;
    assign w_wdata   = {i_desc_src, i_desc_dst, i_desc_width, i_desc_height, i_desc_stride};

    dma_2d_desc_fifo #(
        .WIDTH (c_DESC_W),
        .DEPTH (QUEUE_DEPTH)
    ) u_fifo (
        .ACLK    (ACLK),
        .ARESETN (ARESETN),
        .i_push  (w_push),
        .i_wdata (w_wdata),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (o_q_level)
    );

    always_comb begin
        state_d    = state_q;
        done_d     = i_dma_done;
        wdog_d     = wdog_q;
        src_d      = src_q;
        dst_d      = dst_q;
        width_d    = width_q;
        height_d   = height_q;
        stride_d   = stride_q;
        err_d      = err_q;
        w_pop      = 1'b0;
        // Pulses are registered off the current state, landing one cycle later.
        start_d    = (state_q == ST_LOAD);
        irq_d      = (state_q == ST_RETIRE);
        done_cnt_d = irq_d ? done_cnt_q + 1'b1 : done_cnt_q;

        if (i_clear_err) err_d = '0;
        if (w_reject)    err_d[c_ERR_REJ] = 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (i_enable && !w_empty && (err_q == '0)) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                w_pop    = 1'b1;
                src_d    = w_head[c_OFS_SRC +: ADDR_WIDTH];
                dst_d    = w_head[c_OFS_DST +: ADDR_WIDTH];
                width_d  = w_head[2*DIM_WIDTH +: DIM_WIDTH];
                height_d = w_head[DIM_WIDTH +: DIM_WIDTH];
                stride_d = w_head[0 +: DIM_WIDTH];
                state_d  = ST_START;
            end
            ST_START: begin
                wdog_d  = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // Only a fresh rising edge counts; a level left over from a
                // previous transfer must not retire this one.
                if (i_dma_done && !done_q) begin
                    state_d = ST_RETIRE;
                end else if (c_WDOG_EN && (wdog_q == c_WDOG_LIMIT)) begin
                    err_d[c_ERR_WDOG] = 1'b1;
                    state_d           = ST_ERROR;
                end else begin
                    wdog_d = sat_inc(wdog_q);
                end
            end
            ST_RETIRE: begin
                state_d = ST_IDLE;
            end
            ST_ERROR: begin
                if (i_clear_err) state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE) && (state_d != ST_ERROR);
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q    <= ST_IDLE;
            done_q     <= 1'b0;
            wdog_q     <= '0;
            src_q      <= '0;
            dst_q      <= '0;
            width_q    <= '0;
            height_q   <= '0;
            stride_q   <= '0;
            start_q    <= 1'b0;
            irq_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_cnt_q <= '0;
            err_q      <= '0;
        end else begin
            state_q    <= state_d;
            done_q     <= done_d;
            wdog_q     <= wdog_d;
            src_q      <= src_d;
            dst_q      <= dst_d;
            width_q    <= width_d;
            height_q   <= height_d;
            stride_q   <= stride_d;
            start_q    <= start_d;
            irq_q      <= irq_d;
            busy_q     <= busy_d;
            done_cnt_q <= done_cnt_d;
            err_q      <= err_d;
        end
    end

    assign o_desc_ready = !w_full;
    assign o_dma_start  = start_q;
    assign o_src_addr   = src_q;
    assign o_dst_addr   = dst_q;
    assign o_img_width  = width_q;
    assign o_img_height = height_q;
    assign o_img_stride = stride_q;
    assign o_busy       = busy_q;
    assign o_done_cnt   = done_cnt_q;
    assign o_irq        = irq_q;
    assign o_err        = err_q;

endmodule : dma_2d_desc_sched
`default_nettype wire

// File: tb/tb_dma_2d_desc_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_dma_2d_desc_sched
// Description : Directed self-checking bench for the descriptor scheduler
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dma_2d_desc_sched;

    localparam int c_QD   = 4;
    localparam int c_AW   = 32;
    localparam int c_DW   = 32;
    localparam int c_WDOG = 100;

    logic            ACLK = 1'b0;
    logic            ARESETN = 1'b0;
    logic            i_desc_valid = 1'b0;
    logic            o_desc_ready;
    logic [c_AW-1:0] i_desc_src = '0, i_desc_dst = '0;
    logic [c_DW-1:0] i_desc_width = '0, i_desc_height = '0, i_desc_stride = '0;
    logic            i_enable = 1'b0;
    logic            i_clear_err = 1'b0;
    logic            o_dma_start;
    logic [c_AW-1:0] o_src_addr, o_dst_addr;
    logic [c_DW-1:0] o_img_width, o_img_height, o_img_stride;
    logic            i_dma_done = 1'b0;
    logic            o_busy;
    logic [2:0]      o_q_level;
    logic [15:0]     o_done_cnt;
    logic            o_irq;
    logic [1:0]      o_err;

    int n_tests = 0;
    int n_fail  = 0;

    dma_2d_desc_sched #(
        .QUEUE_DEPTH (c_QD),
        .ADDR_WIDTH  (c_AW),
        .DIM_WIDTH   (c_DW),
        .WDOG_CYCLES (c_WDOG)
    ) u_dut (
        .ACLK          (ACLK),
        .ARESETN       (ARESETN),
        .i_desc_valid  (i_desc_valid),
        .o_desc_ready  (o_desc_ready),
        .i_desc_src    (i_desc_src),
        .i_desc_dst    (i_desc_dst),
        .i_desc_width  (i_desc_width),
        .i_desc_height (i_desc_height),
        .i_desc_stride (i_desc_stride),
        .i_enable      (i_enable),
        .i_clear_err   (i_clear_err),
        .o_dma_start   (o_dma_start),
        .o_src_addr    (o_src_addr),
        .o_dst_addr    (o_dst_addr),
        .o_img_width   (o_img_width),
        .o_img_height  (o_img_height),
        .o_img_stride  (o_img_stride),
        .i_dma_done    (i_dma_done),
        .o_busy        (o_busy),
        .o_q_level     (o_q_level),
        .o_done_cnt    (o_done_cnt),
        .o_irq         (o_irq),
        .o_err         (o_err)
    );

    always #5 ACLK = ~ACLK;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Cycle n is the interval that follows rising edge n.
    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic push_desc(input logic [31:0] src, input logic [31:0] dst,
                             input logic [31:0] w, input logic [31:0] h,
                             input logic [31:0] s);
        i_desc_src    = src;
        i_desc_dst    = dst;
        i_desc_width  = w;
        i_desc_height = h;
        i_desc_stride = s;
        i_desc_valid  = 1'b1;
        tick();
        i_desc_valid  = 1'b0;
    endtask

    task automatic wait_start(input int budget, output bit found);
        found = 1'b0;
        for (int i = 0; i < budget && !found; i++) begin
            tick();
            if (o_dma_start) found = 1'b1;
        end
    endtask

    task automatic wait_irq(input int budget, output bit found);
        found = 1'b0;
        for (int i = 0; i < budget && !found; i++) begin
            tick();
            if (o_irq) found = 1'b1;
        end
    endtask

    // Called in the START cycle: one WAIT cycle, then a one-cycle done pulse.
    task automatic finish_xfer();
        bit got;
        tick();
        i_dma_done = 1'b1;
        tick();
        i_dma_done = 1'b0;
        wait_irq(5, got);
        check_eq("irq_seen", got, 1);
    endtask

    task automatic count_starts(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (o_dma_start) n++;
        end
    endtask

    initial begin
        bit got;
        int n;
        int lat;

        // Reset state
        tick(); tick();
        check_eq("rst_start", o_dma_start, 0);
        check_eq("rst_busy",  o_busy, 0);
        check_eq("rst_irq",   o_irq, 0);
        check_eq("rst_err",   o_err, 0);
        check_eq("rst_cnt",   o_done_cnt, 0);
        check_eq("rst_level", o_q_level, 0);
        check_eq("rst_ready", o_desc_ready, 1);
        check_eq("rst_src",   o_src_addr, 0);
        check_eq("rst_width", o_img_width, 0);
        ARESETN = 1'b1;
        tick();

        // Single descriptor: push at edge k, LOAD at k+1, start at k+2
        i_enable = 1'b1;
        push_desc(32'h1000, 32'h2000, 16, 4, 64);
        check_eq("s_level_k",  o_q_level, 1);
        check_eq("s_start_k",  o_dma_start, 0);
        tick();
        check_eq("s_start_k1", o_dma_start, 0);
        check_eq("s_busy_k1",  o_busy, 1);
        tick();
        check_eq("s_start_k2", o_dma_start, 1);
        check_eq("s_src",      o_src_addr, 32'h1000);
        check_eq("s_dst",      o_dst_addr, 32'h2000);
        check_eq("s_width",    o_img_width, 16);
        check_eq("s_height",   o_img_height, 4);
        check_eq("s_stride",   o_img_stride, 64);
        tick();
        check_eq("s_start_k3", o_dma_start, 0);
        check_eq("s_level_k3", o_q_level, 0);
        i_dma_done = 1'b1;
        tick();
        i_dma_done = 1'b0;
        check_eq("s_irq_d",    o_irq, 0);
        check_eq("s_src_hold", o_src_addr, 32'h1000);
        tick();
        check_eq("s_irq_d1",   o_irq, 1);
        check_eq("s_cnt",      o_done_cnt, 1);
        tick();
        check_eq("s_irq_d2",   o_irq, 0);
        check_eq("s_busy_d2",  o_busy, 0);

        // Queue fill with enable low; the fifth push must be refused
        i_enable = 1'b0;
        for (int i = 0; i < 4; i++)
            push_desc(32'hA000 + 32'h100 * i, 32'hE000 + 32'h100 * i, i + 1, 2, 32'h40);
        check_eq("q_level4", o_q_level, 4);
        check_eq("q_ready0", o_desc_ready, 0);
        push_desc(32'hA400, 32'hE400, 5, 2, 32'h40);
        check_eq("q_level_hold", o_q_level, 4);
        i_enable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_start(10, got);
            check_eq("q_start_seen", got, 1);
            check_eq("q_order_src", o_src_addr, 32'hA000 + 32'h100 * i);
            check_eq("q_order_w",   o_img_width, i + 1);
            finish_xfer();
        end
        count_starts(20, n);
        check_eq("q_no_5th", n, 0);
        check_eq("q_cnt", o_done_cnt, 5);

        // Stale done level held through START must be ignored
        i_dma_done = 1'b1;
        tick();
        push_desc(32'h5000, 32'h6000, 8, 8, 8);
        wait_start(10, got);
        check_eq("st_start_seen", got, 1);
        got = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (o_irq) got = 1'b1;
        end
        check_eq("st_no_irq", got, 0);
        check_eq("st_busy", o_busy, 1);
        i_dma_done = 1'b0;
        tick();
        i_dma_done = 1'b1;
        tick();
        i_dma_done = 1'b0;
        wait_irq(5, got);
        check_eq("st_irq_seen", got, 1);
        check_eq("st_cnt", o_done_cnt, 6);

        // Watchdog timeout with a second descriptor still queued
        i_enable = 1'b0;
        push_desc(32'hB000, 32'hC000, 4, 4, 4);
        push_desc(32'hB100, 32'hC100, 4, 4, 4);
        i_enable = 1'b1;
        wait_start(10, got);
        check_eq("wd_start_seen", got, 1);
        check_eq("wd_src", o_src_addr, 32'hB000);
        lat = 0;
        while (o_err == 2'b00 && lat < 200) begin
            tick();
            lat++;
        end
        check_eq("wd_latency_ok", (lat >= 101 && lat <= 102), 1);
        check_eq("wd_err", o_err, 2'b01);
        check_eq("wd_busy", o_busy, 0);
        check_eq("wd_level", o_q_level, 1);
        count_starts(15, n);
        check_eq("wd_blocked", n, 0);
        i_clear_err = 1'b1;
        tick();
        i_clear_err = 1'b0;
        check_eq("wd_cleared", o_err, 0);
        wait_start(10, got);
        check_eq("wd_resume_seen", got, 1);
        check_eq("wd_resume_src", o_src_addr, 32'hB100);
        finish_xfer();
        check_eq("wd_cnt", o_done_cnt, 7);

        // Zero-height push is consumed, flagged and blocks launches
        push_desc(32'hD000, 32'hD800, 4, 0, 4);
        check_eq("z_level", o_q_level, 0);
        check_eq("z_err", o_err, 2'b10);
        push_desc(32'hC000, 32'hC800, 2, 2, 2);
        count_starts(10, n);
        check_eq("z_blocked", n, 0);
        check_eq("z_level1", o_q_level, 1);
        i_clear_err = 1'b1;
        tick();
        i_clear_err = 1'b0;
        wait_start(10, got);
        check_eq("z_resume_seen", got, 1);
        check_eq("z_src", o_src_addr, 32'hC000);
        finish_xfer();
        check_eq("z_cnt", o_done_cnt, 8);

        // Reset while waiting with two descriptors still queued
        i_enable = 1'b0;
        for (int i = 0; i < 3; i++)
            push_desc(32'hF000 + 32'h10 * i, 32'hF800, 1, 1, 1);
        i_enable = 1'b1;
        wait_start(10, got);
        check_eq("r_start_seen", got, 1);
        tick(); tick();
        check_eq("r_level2", o_q_level, 2);
        i_enable = 1'b0;
        ARESETN = 1'b0;
        #1;
        check_eq("r_start", o_dma_start, 0);
        check_eq("r_busy",  o_busy, 0);
        check_eq("r_level", o_q_level, 0);
        check_eq("r_ready", o_desc_ready, 1);
        check_eq("r_cnt",   o_done_cnt, 0);
        check_eq("r_err",   o_err, 0);
        check_eq("r_src",   o_src_addr, 0);
        tick();
        ARESETN = 1'b1;
        i_enable = 1'b1;
        count_starts(10, n);
        check_eq("r_idle_after", n, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete, expected finish");
        $fatal(1, "timeout");
    end

endmodule : tb_dma_2d_desc_sched
`default_nettype wire

// File: doc/dma_2d_desc_sched.md
# dma_2d_desc_sched

Descriptor scheduler that sequences the 2D DMA engine (read master, FIFO, write master) without CPU involvement between transfers. Software pushes up to QUEUE_DEPTH 2D transfer descriptors (src, dst, width, height, stride) into an internal queue. The block issues them one at a time to the engine's start/parameter inputs, waits for completion, counts retirements and raises an interrupt pulse per descriptor. It sits between the AXI-Lite slave register file and the read/write masters, replacing the direct start path.

## Interface
- QUEUE_DEPTH, 4, descriptor queue entries; power of 2, minimum 2.
- ADDR_WIDTH, 32, source/destination address width.
- DIM_WIDTH, 32, width/height/stride field width.
- WDOG_CYCLES, 1048576, cycles allowed in WAIT before timeout; 0 disables the watchdog.
- ACLK  in  1  clock; all logic rising-edge.
- ARESETN  in  1  asynchronous active-low reset.
- i_desc_valid  in  1  descriptor push request.
- o_desc_ready  out  1  queue not full.
- i_desc_src, i_desc_dst  in  ADDR_WIDTH  descriptor addresses.
- i_desc_width, i_desc_height, i_desc_stride  in  DIM_WIDTH  descriptor geometry.
- i_enable  in  1  run; allows new descriptors to launch.
- i_clear_err  in  1  clears o_err and leaves ERROR.
- o_dma_start  out  1  one-cycle start pulse to the engine.
- o_src_addr, o_dst_addr  out  ADDR_WIDTH  active descriptor addresses.
- o_img_width, o_img_height, o_img_stride  out  DIM_WIDTH  active descriptor geometry.
- i_dma_done  in  1  engine write-complete level (wr_done).
- o_busy  out  1  state is not IDLE and not ERROR.
- o_q_level  out  $clog2(QUEUE_DEPTH)+1  queued descriptors.
- o_done_cnt  out  16  retired descriptor count; wraps modulo 2^16.
- o_irq  out  1  one-cycle pulse per retired descriptor.
- o_err  out  2  sticky errors: bit0 watchdog timeout, bit1 rejected descriptor.

## Operation
- Push: a descriptor is accepted when i_desc_valid and o_desc_ready are high on a clock edge.
- Rejection: a descriptor with width==0 or height==0 is consumed but not enqueued, and sets o_err[1].
- FSM states:
  - IDLE: go to LOAD when i_enable is high, the queue is non-empty and o_err==0.
  - LOAD: pop the head into the o_src_addr..o_img_stride registers, then go to START.
  - START: o_dma_start=1 for exactly this cycle; clear the watchdog; go to WAIT.
  - WAIT: a rising edge of i_dma_done (i_dma_done & ~done_q, with done_q registered) goes to RETIRE. A level already high at START is ignored. If the watchdog equals WDOG_CYCLES (non-zero), set o_err[0] and go to ERROR.
  - RETIRE: o_done_cnt+1 and o_irq=1; go to IDLE.
  - ERROR: no launches; the queue keeps its contents and pushes are still accepted; i_clear_err clears o_err and goes to IDLE.
- i_clear_err in any other state clears o_err only.
- o_err[1] set while in IDLE also blocks launches until cleared.
- Parameter outputs are held stable from LOAD until the next LOAD.
- i_enable deasserted mid-transfer: the current descriptor completes and retires; no new LOAD.
- Push and pop in the same cycle: both occur and o_q_level is unchanged. A push while full is not accepted.
- Watchdog counter is 32-bit and saturates.

## Timing
- Reset values: o_dma_start=0, o_busy=0, o_irq=0, o_err=0, o_done_cnt=0, o_q_level=0, o_desc_ready=1, all parameter outputs 0, state IDLE, queue empty.
- Launch latency: a push accepted at edge k into an empty queue, with i_enable high, gives LOAD in cycle k+1 and o_dma_start in cycle k+2.
- Retire latency: a done rising edge sampled at edge d gives o_irq in cycle d+1 and the earliest next o_dma_start in cycle d+3.
- o_q_level and o_desc_ready update the cycle after push/pop.
- Reset mid-transfer: the queue is flushed and state returns to IDLE. This block does not reset the engine.

## Structure
- Shared package dma_2d_pkg: FSM state encoding (IDLE, LOAD, START, WAIT, RETIRE, ERROR), descriptor field widths, error bit indices.
- Sub-module dma_2d_desc_fifo: synchronous FIFO, width 2*ADDR_WIDTH+3*DIM_WIDTH, depth QUEUE_DEPTH, with pointer-wrap level counter, full/empty flags and an async active-low reset.

## Test plan
- Single descriptor: push src=0x1000, dst=0x2000, 16x4, stride=64 with enable high. Expect o_dma_start at cycle k+2, outputs held, done edge, o_irq one cycle, o_done_cnt=1.
- Queue fill: with enable low, push 5 descriptors. Expect the 4th to fill the queue, o_desc_ready=0 and the 5th not accepted, o_q_level=4. Raise enable: exactly 4 starts in FIFO order, o_done_cnt=4.
- Stale done: hold i_dma_done high before START. Expect no retire until it falls and rises again.
- Watchdog: WDOG_CYCLES=100, done never asserted. Expect o_err=2'b01 at cycle 100 of WAIT and no further starts; i_clear_err resumes the remaining queue.
- Zero-dimension push: height=0. Expect the descriptor not enqueued, o_err[1]=1 and launches blocked until i_clear_err.
- Reset mid-WAIT with 2 queued: assert ARESETN low. Expect all outputs at reset values and o_q_level=0.
